// File: rtl/temporizador_multi.sv
// Preset down-counter timer with prescaler, pause and auto-reload.
// Reports a level ready flag (count at zero) and a one-cycle expiry pulse.
module temporizador_multi #(
  parameter int WIDTH = 4,
  parameter int SEL_W = 2,
  parameter logic [(2**SEL_W)*WIDTH-1:0] PRESETS = {4'd12, 4'd7, 4'd3, 4'd0},
  parameter int PRESC = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             carga_temp_i,
  input  logic [SEL_W-1:0] temp_sel_i,
  input  logic             pausa_i,
  input  logic             auto_recarga_i,
  output logic [WIDTH-1:0] contador_o,
  output logic             listo_o,
  output logic             fin_o
);

  localparam int PW = $clog2(PRESC) + 1;

  logic [WIDTH-1:0] contador_q, contador_d;
  logic [WIDTH-1:0] recarga_q, recarga_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic             fin_q, fin_d;
  logic [WIDTH-1:0] presetSel;
  logic             tick;

  assign presetSel = PRESETS[temp_sel_i*WIDTH +: WIDTH];
  assign tick      = (presc_q == PW'(PRESC - 1));

  // Priority: load > pause > idle at zero > tick/prescale.
  always_comb begin
    contador_d = contador_q;
    recarga_d  = recarga_q;
    presc_d    = presc_q;
    fin_d      = 1'b0;
    if (carga_temp_i) begin
      contador_d = presetSel;
      recarga_d  = presetSel;
      presc_d    = '0;
    end else if (pausa_i) begin
      fin_d = 1'b0;
    end else if (contador_q == '0) begin
      presc_d = '0;
    end else if (tick) begin
      presc_d = '0;
      if (contador_q == WIDTH'(1)) begin
        fin_d      = 1'b1;
        contador_d = auto_recarga_i ? recarga_q : '0;
      end else begin
        contador_d = contador_q - WIDTH'(1);
      end
    end else begin
      presc_d = presc_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      contador_q <= '0;
      recarga_q  <= '0;
      presc_q    <= '0;
      fin_q      <= 1'b0;
    end else begin
      contador_q <= contador_d;
      recarga_q  <= recarga_d;
      presc_q    <= presc_d;
      fin_q      <= fin_d;
    end
  end

  assign contador_o = contador_q;
  assign listo_o    = (contador_q == '0);
  assign fin_o      = fin_q;

endmodule

// File: tb/tb_temporizador_multi.sv
// Bench for temporizador_multi: two instances (PRESC=1 and PRESC=3) checked
// against a remaining-cycles reference model plus directed spot checks.
module tb_temporizador_multi;

  logic       clk = 1'b0;
  logic       reset, carga, pausa, autoRec;
  logic [1:0] sel;
  logic [3:0] cnt1, cnt3;
  logic       listo1, listo3, fin1, fin3;

  always #5 clk = ~clk;

  temporizador_multi #(.PRESC(1)) dut1 (
    .clk(clk), .reset(reset), .carga_temp_i(carga), .temp_sel_i(sel),
    .pausa_i(pausa), .auto_recarga_i(autoRec),
    .contador_o(cnt1), .listo_o(listo1), .fin_o(fin1)
  );

  temporizador_multi #(.PRESC(3)) dut3 (
    .clk(clk), .reset(reset), .carga_temp_i(carga), .temp_sel_i(sel),
    .pausa_i(pausa), .auto_recarga_i(autoRec),
    .contador_o(cnt3), .listo_o(listo3), .fin_o(fin3)
  );

  int presets [4] = '{0, 3, 7, 12};
  int pv      [2] = '{1, 3};
  // Model state: clock cycles left until expiry, last loaded preset, pulse.
  int remaining [2];
  int reload    [2];
  bit finExp    [2];
  int nTests = 0;
  int nFail  = 0;

  // The count shown is the number of whole-or-partial ticks still to elapse.
  task automatic modelEdge();
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        remaining[d] = 0; reload[d] = 0; finExp[d] = 0;
      end else if (carga) begin
        reload[d] = presets[sel]; remaining[d] = reload[d] * pv[d]; finExp[d] = 0;
      end else if (pausa || remaining[d] == 0) begin
        finExp[d] = 0;
      end else begin
        remaining[d] = remaining[d] - 1;
        finExp[d] = (remaining[d] == 0);
        if (remaining[d] == 0 && autoRec) remaining[d] = reload[d] * pv[d];
      end
    end
  endtask

  task automatic checkOutput();
    for (int d = 0; d < 2; d++) begin
      logic [3:0] c, expC;
      logic       l, f;
      c = (d == 0) ? cnt1 : cnt3;
      l = (d == 0) ? listo1 : listo3;
      f = (d == 0) ? fin1 : fin3;
      expC = 4'((remaining[d] + pv[d] - 1) / pv[d]);
      nTests++;
      assert (c === expC) else begin
        nFail++;
        $error("FAIL contador_p%0d got %0d expected %0d", pv[d], c, expC);
      end
      nTests++;
      assert (l === (expC == 4'd0)) else begin
        nFail++;
        $error("FAIL listo_p%0d got %b expected %b", pv[d], l, (expC == 4'd0));
      end
      nTests++;
      assert (f === finExp[d]) else begin
        nFail++;
        $error("FAIL fin_p%0d got %b expected %b", pv[d], f, finExp[d]);
      end
    end
  endtask

  task automatic expectVal(input string tag, input int got, input int exp);
    nTests++;
    assert (got === exp) else begin
      nFail++;
      $error("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic c, input logic p,
                               input logic a, input logic [1:0] s);
    reset = r; carga = c; pausa = p; autoRec = a; sel = s;
    @(posedge clk);
    modelEdge();
    #1;
    checkOutput();
  endtask

  initial begin
    int finCount, listoCount;
    reset = 1'b1; carga = 1'b0; pausa = 1'b0; autoRec = 1'b0; sel = 2'd0;

    // Reset and quiet idle
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    expectVal("reset_contador", cnt1, 0);
    expectVal("reset_listo", listo1, 1);
    expectVal("reset_fin", fin1, 0);
    for (int i = 0; i < 10; i++) applyStimulus(0, 0, 0, 0, 0);
    expectVal("idle_contador", cnt1, 0);

    // One-shot, preset 3
    applyStimulus(0, 1, 0, 0, 1);
    expectVal("oneshot_k0", cnt1, 3);
    applyStimulus(0, 0, 0, 0, 0);
    expectVal("oneshot_k1", cnt1, 2);
    applyStimulus(0, 0, 0, 0, 0);
    expectVal("oneshot_k2", cnt1, 1);
    expectVal("oneshot_k2_fin", fin1, 0);
    applyStimulus(0, 0, 0, 0, 0);
    expectVal("oneshot_k3", cnt1, 0);
    expectVal("oneshot_k3_fin", fin1, 1);
    expectVal("oneshot_k3_listo", listo1, 1);
    applyStimulus(0, 0, 0, 0, 0);
    expectVal("oneshot_k4_fin", fin1, 0);
    for (int i = 0; i < 10; i++) applyStimulus(0, 0, 0, 0, 0);

    // Pause mid-count, preset 7
    applyStimulus(0, 1, 0, 0, 2);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 0);
    applyStimulus(0, 0, 1, 0, 0);
    expectVal("pause_hold", cnt1, 4);
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    expectVal("pause_k8_listo", listo1, 0);
    applyStimulus(0, 0, 0, 0, 0);
    expectVal("pause_k9_listo", listo1, 1);
    expectVal("pause_k9_fin", fin1, 1);
    for (int i = 0; i < 20; i++) applyStimulus(0, 0, 0, 0, 0);

    // Preset 0 never pulses, even in auto mode
    applyStimulus(0, 1, 0, 1, 0);
    expectVal("preset0_listo", listo1, 1);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 0, 0, 1, 0);
      expectVal("preset0_fin", fin1, 0);
    end

    // Auto-reload, period 7
    applyStimulus(0, 1, 0, 1, 2);
    finCount = 0; listoCount = 0;
    for (int i = 0; i < 28; i++) begin
      applyStimulus(0, 0, 0, 1, 0);
      if (fin1) finCount++;
      if (listo1) listoCount++;
    end
    expectVal("auto_fin_pulses", finCount, 4);
    expectVal("auto_listo_never", listoCount, 0);
    for (int i = 0; i < 30; i++) applyStimulus(0, 0, 0, 0, 0);
    expectVal("auto_drop_stop", cnt1, 0);
    expectVal("auto_drop_stop_p3", cnt3, 0);

    // Load on the terminal tick wins
    applyStimulus(0, 1, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 3);
    expectVal("prio_load_cnt", cnt1, 12);
    expectVal("prio_load_fin", fin1, 0);
    // Reset on the terminal tick suppresses fin
    applyStimulus(0, 1, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    expectVal("prio_reset_cnt", cnt1, 0);
    expectVal("prio_reset_fin", fin1, 0);
    // Reset with load gives reset values
    applyStimulus(1, 1, 0, 0, 3);
    expectVal("prio_reset_load", cnt1, 0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      applyStimulus(($urandom_range(0, 49) == 0), ($urandom_range(0, 7) == 0),
                    ($urandom_range(0, 5) == 0),
                    ($urandom_range(0, 19) == 0) ? ~autoRec : autoRec,
                    2'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule

// File: doc/temporizador_multi.md
# temporizador_multi

Parametrised successor of the single-channel preset down-counter timer used by the control FSMs for settle, conversion and wait intervals. It loads one of 2**SEL_W compile-time presets, counts down at a prescaled rate, and supports pause and an auto-reload (periodic) mode. It reports both a level ready flag and a one-cycle expiry pulse. It sits beside the sequencing FSM, which loads it with `carga_temp` and polls `listo` or reacts to `fin`.

## Interface
- `WIDTH`, 4: counter and preset width in bits.
- `SEL_W`, 2: preset select width; there are NPRE = 2**SEL_W presets.
- `PRESETS`, {4'd12,4'd7,4'd3,4'd0}: flattened preset vector. Preset i = `PRESETS[i*WIDTH +: WIDTH]`; the default gives i0=0, i1=3, i2=7, i3=12.
- `PRESC`, 1: clock cycles per count tick, ≥1. A prescaler of width clog2(PRESC)+1 is used.
- `clk` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high; highest priority.
- `carga_temp` in 1: load strobe; sampled every cycle.
- `temp_sel` in SEL_W: preset index, sampled only when `carga_temp`=1.
- `pausa` in 1: hold; freezes the counter and the prescaler.
- `auto_recarga` in 1: 1 = periodic mode, 0 = one-shot; sampled continuously.
- `contador` out WIDTH: current count (register).
- `listo` out 1: `contador`==0 (combinational from register, no extra latency).
- `fin` out 1: registered one-cycle expiry pulse.

## Operation
- Registers: `contador`, `recarga` (last loaded preset, WIDTH), `presc` (prescaler), `fin`.
- Per-edge priority: reset > load > pausa > count.
- **Reset:** `contador`=0, `recarga`=0, `presc`=0, `fin`=0. Therefore `listo`=1 out of reset.
- **Load** (`carga_temp`=1):
  - `contador` and `recarga` take preset[`temp_sel`]; `presc`=0; `fin`=0.
  - A load while counting restarts the interval.
  - A load on the terminal tick wins: no `fin`, no reload.
- **Pausa=1:** all registers hold; `fin`=0.
- **Tick:** tick = (`presc`==PRESC-1). When there is no tick, `presc` increments. On a tick, `presc`=0.
- **On a tick with `contador`>1:** decrement by 1; `fin`=0.
- **On a tick with `contador`==1:**
  - `fin`=1 for exactly one cycle.
  - `auto_recarga`=0: `contador`=0.
  - `auto_recarga`=1: `contador`=`recarga` (0 never appears, so `listo` stays 0). If `recarga`==1, `fin` pulses every tick.
- **`contador`==0 (idle):** holds; `presc` is held at 0; `fin`=0. This applies in auto mode too, so a preset of 0 never pulses `fin`.
- **Arithmetic:** unsigned, no wrap below 0. `fin` is the only output that pulses, and never on two consecutive cycles unless `recarga`==1 with PRESC=1.

## Timing
- Load at edge k: `contador`=preset from edge k. With PRESC=P and preset N≥1 (no pause), `contador` reaches 0 (one-shot) at edge k+N·P.
- `fin`=1 in the cycle after edge k+N·P; `listo` rises at that same edge.
- Auto mode: `fin` period is N·P cycles.
- Each cycle with `pausa`=1 delays expiry by exactly one cycle.
- Reset asserted mid-count: outputs take reset values at that edge. Any `fin` pending for that edge is suppressed.
- Changing `auto_recarga` mid-count takes effect at the next terminal tick.

## Test plan
- **Reset:** reset for 2 cycles, default params → `contador`=0, `listo`=1, `fin`=0. With no load for 10 cycles, all outputs stay constant.
- **One-shot:** `carga_temp` with sel=1 at edge k → `contador` 3,2,1,0 at edges k..k+3. `listo`=1 and `fin`=1 for exactly one cycle, both from edge k+3.
- **Pause and preset 0:** sel=2 (7) with `pausa`=1 for 2 cycles mid-count → `listo` rises at edge k+9. Load sel=0 → `listo`=1 next cycle, `fin` never asserts.
- **Auto-reload:** `auto_recarga`=1, sel=2 → `fin` pulses every 7 cycles for 4 periods. `contador` sequence is 7..1 repeating, `listo` never 1. Dropping `auto_recarga` → next expiry holds at 0.
- **Prescaler:** PRESC=3, sel=1 → `fin` 9 cycles after load. `contador` changes every 3rd cycle.
- **Priority:**
  - Load sel=3 on the cycle `contador`==1 → `contador`=12, no `fin`.
  - Reset on the same cycle → `contador`=0, no `fin`.
  - Reset together with `carga_temp` → reset values.
